decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 153 +++++++++++++++
 tb/tb_decode_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with a valid/ready output slot
// and load-use hazard tracking that inserts LOAD_LAT bubbles after a LOAD.
module decode_stage #(
  parameter int D        = 32,
  parameter int RWIDTH   = 6,
  parameter int IMM_IN   = 15,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D-1:0]      in32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rd,
  output logic [RWIDTH-1:0] rt,
  output logic [IMM_IN-1:0] imm,
  output logic [3:0]        ALUopsel,
  output logic              MUXsel1,
  output logic              MUXsel2,
  output logic              WE1,
  output logic              WE2,
  output logic              illegal,
  output logic              stall
);

  // Field positions, counted down from the MSB (I bit at D-1).
  localparam int RS_LSB = D - 1 - RWIDTH;
  localparam int RD_LSB = RS_LSB - RWIDTH;
  localparam int OP_LSB = RD_LSB - 4;
  localparam int IMM_LO = IMM_IN - RWIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  typedef struct packed {
    logic [RWIDTH-1:0] rs;
    logic [RWIDTH-1:0] rd;
    logic [RWIDTH-1:0] rt;
    logic [IMM_IN-1:0] imm;
    logic [3:0]        alu;
    logic              mux1;
    logic              mux2;
    logic              we1;
    logic              we2;
    logic              ill;
  } dec_t;

  dec_t              dec_d, dec_q;
  logic              out_valid_q;
  logic [RWIDTH-1:0] pend_rd_q;
  logic              pend_held_q;
  logic [3:0]        haz_cnt_q;

  logic              ins_i;
  logic [3:0]        ins_op;
  logic [RWIDTH-1:0] ins_rs, ins_rt;
  logic              tracking, hit, hazard, xfer_in, xfer_out;

  assign ins_i  = in32[D-1];
  assign ins_op = in32[OP_LSB +: 4];
  assign ins_rs = in32[RS_LSB +: RWIDTH];
  assign ins_rt = in32[IMM_IN-1 -: RWIDTH];

  // Combinational decode of the incoming word; illegal opcodes fall out as NOPs.
  always_comb begin
    dec_d      = '0;
    dec_d.rs   = ins_rs;
    dec_d.rd   = in32[RD_LSB +: RWIDTH];
    dec_d.mux1 = ins_i;
    dec_d.alu  = 4'b0010;
    if (ins_i) begin
      dec_d.imm = in32[IMM_IN-1:0];
    end else begin
      dec_d.rt  = ins_rt;
      dec_d.imm = {{RWIDTH{1'b0}}, in32[IMM_LO-1:0]};
    end
    case (ins_op)
      4'b0000, 4'b0011, 4'b1000, 4'b1001,
      4'b1010, 4'b1011, 4'b1101: dec_d.alu = ins_op;
      4'b0010, 4'b1111:          dec_d.ill = 1'b0;
      4'b0100: begin
        dec_d.mux2 = 1'b1;
        dec_d.we1  = 1'b1;
      end
      4'b0110: begin
        dec_d.mux2 = 1'b1;
        dec_d.we2  = 1'b1;
      end
      default:                   dec_d.ill = 1'b1;
    endcase
  end

  // A LOAD is tracked while it sits in the output slot and for LOAD_LAT-1
  // cycles after it leaves; rt only counts as a source in register mode.
  assign tracking = pend_held_q || (haz_cnt_q != 4'd0);
  assign hit      = (ins_rs == pend_rd_q) || (!ins_i && (ins_rt == pend_rd_q));
  assign hazard   = in_valid && tracking && hit;
  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign stall    = !rst && hazard;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid_q && out_ready;

  // Output slot: load on accept, empty on drain; flush beats any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (xfer_in) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_d;
    end else if (xfer_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // Hazard tracker: a newly accepted LOAD restarts tracking from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd_q   <= '0;
      pend_held_q <= 1'b0;
      haz_cnt_q   <= 4'd0;
    end else if (flush) begin
      pend_held_q <= 1'b0;
      haz_cnt_q   <= 4'd0;
    end else if (xfer_in && dec_d.we1) begin
      pend_rd_q   <= dec_d.rd;
      pend_held_q <= 1'b1;
      haz_cnt_q   <= 4'd0;
    end else if (xfer_out && dec_q.we1) begin
      pend_held_q <= 1'b0;
      haz_cnt_q   <= LAT_M1;
    end else if (!pend_held_q && (haz_cnt_q != 4'd0)) begin
      haz_cnt_q   <= haz_cnt_q - 4'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign rs        = dec_q.rs;
  assign rd        = dec_q.rd;
  assign rt        = dec_q.rt;
  assign imm       = dec_q.imm;
  assign ALUopsel  = dec_q.alu;
  assign MUXsel1   = dec_q.mux1;
  assign MUXsel2   = dec_q.mux2;
  assign WE1       = dec_q.we1;
  assign WE2       = dec_q.we2;
  assign illegal   = dec_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (LOAD_LAT=1 and 3) sharing all inputs
// except in_valid; expected fields come from a field-arithmetic reference.
module tb_decode_stage;
  localparam int D = 32, RW = 6, IW = 15;

  typedef struct packed {
    logic [RW-1:0] rs, rd, rt;
    logic [IW-1:0] imm;
    logic [3:0]    alu;
    logic          mux1, mux2, we1, we2, ill;
  } dec_t;

  logic          clk = 1'b0;
  logic          rst, flush, out_ready;
  logic [D-1:0]  in32;
  logic [1:0]    in_valid, in_ready, out_valid, mux1, mux2, we1, we2, ill, stall;
  logic [RW-1:0] rs_o [2], rd_o [2], rt_o [2];
  logic [IW-1:0] imm_o [2];
  logic [3:0]    alu_o [2];

  int errors = 0, checks = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(.D(D), .RWIDTH(RW), .IMM_IN(IW), .LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in32(in32),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .rs(rs_o[g]), .rd(rd_o[g]), .rt(rt_o[g]), .imm(imm_o[g]),
      .ALUopsel(alu_o[g]), .MUXsel1(mux1[g]), .MUXsel2(mux2[g]),
      .WE1(we1[g]), .WE2(we2[g]), .illegal(ill[g]), .stall(stall[g])
    );
  end

  function automatic logic [31:0] mk(bit i, int r1, int r2, int op, int low);
    return {i, 6'(r1), 6'(r2), 4'(op), 15'(low)};
  endfunction

  // Reference decode straight from the field layout and opcode table.
  function automatic dec_t ref_dec(logic [31:0] w);
    dec_t e;
    int unsigned u, op, low, i;
    u = w;
    e = '0;
    i = (u >> 31) & 1;
    e.rs = 6'((u >> 25) % 64);
    e.rd = 6'((u >> 19) % 64);
    op   = (u >> 15) % 16;
    low  = u % 32768;
    if (i == 1) e.imm = 15'(low);
    else begin
      e.rt  = 6'(low / 512);
      e.imm = 15'(low % 512);
    end
    e.alu  = (op inside {0, 3, 8, 9, 10, 11, 13}) ? 4'(op) : 4'd2;
    e.ill  = !(op inside {0, 2, 3, 4, 6, 8, 9, 10, 11, 13, 15});
    e.mux1 = (i == 1);
    e.mux2 = (op == 4) || (op == 6);
    e.we1  = (op == 4);
    e.we2  = (op == 6);
    return e;
  endfunction

  function automatic dec_t act(int g);
    dec_t a;
    a.rs = rs_o[g]; a.rd = rd_o[g]; a.rt = rt_o[g]; a.imm = imm_o[g]; a.alu = alu_o[g];
    a.mux1 = mux1[g]; a.mux2 = mux2[g]; a.we1 = we1[g]; a.we2 = we2[g]; a.ill = ill[g];
    return a;
  endfunction

  function automatic logic [31:0] rand_noload();
    int op;
    op = $urandom_range(0, 15);
    if (op == 4) op = 0;
    return mk(1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63), op, $urandom);
  endfunction

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic test_reset();
    dec_t a;
    rst = 1; in_valid = 2'b11; in32 = mk(0, 7, 7, 4, 0);
    step(); step(); smp();
    for (int g = 0; g < 2; g++) begin
      a = act(g);
      checks++;
      if (in_ready[g] !== 1'b0 || stall[g] !== 1'b0 || out_valid[g] !== 1'b0) begin
        errors++; $display("FAIL reset_hs g%0d: rdy=%b stall=%b ov=%b want 0 0 0", g, in_ready[g], stall[g], out_valid[g]);
      end
      checks++;
      if (a !== '0) begin errors++; $display("FAIL reset_fields g%0d: got %h want 0", g, a); end
    end
    step(); rst = 0; in_valid = 2'b00;
  endtask

  task automatic test_basic();
    dec_t a, e;
    in32 = 32'h8A0000FF; in_valid = 2'b01; out_ready = 1;
    smp();
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", in_ready[0]); end
    step(); in_valid = 2'b00; smp();
    a = act(0); e = ref_dec(32'h8A0000FF);
    checks++;
    if (out_valid[0] !== 1'b1 || a !== e) begin errors++; $display("FAIL basic_decode: ov=%b got %h want %h", out_valid[0], a, e); end
    checks++;
    if (a.rs !== 6'd5 || a.rt !== 6'd0 || a.imm !== 15'h00FF || a.alu !== 4'd0 || a.mux1 !== 1'b1 ||
        a.we1 !== 1'b0 || a.we2 !== 1'b0 || a.ill !== 1'b0) begin
      errors++; $display("FAIL basic_const: got %h want rs=5 imm=00ff alu=0 mux1=1", a);
    end
    step();
  endtask

  task automatic test_opcode_sweep();
    logic [31:0] w;
    dec_t a, e;
    for (int op = 0; op < 16; op++) begin
      w = mk(0, $urandom_range(0, 63), $urandom_range(0, 63), op, $urandom);
      in32 = w; in_valid = 2'b01;
      smp();
      checks++;
      if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL sweep_ready op%0d: got %b want 1", op, in_ready[0]); end
      step(); in_valid = 2'b00; smp();
      a = act(0); e = ref_dec(w);
      checks++;
      if (out_valid[0] !== 1'b1 || a !== e) begin errors++; $display("FAIL sweep op%0d: ov=%b got %h want %h", op, out_valid[0], a, e); end
      step(); step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    int idx, got;
    dec_t a, e;
    for (int i = 0; i < 5; i++) words[i] = rand_noload();
    q.delete();
    out_ready = 0; in32 = words[0]; in_valid = 2'b01;
    smp(); q.push_back(words[0]);
    step(); in32 = words[1];
    for (int c = 0; c < 3; c++) begin
      smp(); a = act(0); e = ref_dec(words[0]);
      checks++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || a !== e) begin
        errors++; $display("FAIL bp_hold c%0d: rdy=%b ov=%b got %h want %h", c, in_ready[0], out_valid[0], a, e);
      end
      step();
    end
    out_ready = 1; idx = 1; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      smp();
      if (out_valid[0] && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra: output with empty queue"); end
        else begin
          e = ref_dec(q.pop_front()); a = act(0);
          if (a !== e) begin errors++; $display("FAIL bp_data: got %h want %h", a, e); end
        end
        got++;
      end
      if (idx < 5) begin
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_thru idx%0d: in_ready=%b want 1", idx, in_ready[0]); end
        if (in_valid[0] && in_ready[0]) begin q.push_back(words[idx]); idx++; end
      end
      step();
      if (idx < 5) in32 = words[idx]; else in_valid = 2'b00;
    end
    checks++;
    if (got != 5 || q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d left %0d want 5 0", got, q.size()); end
    in_valid = 2'b00;
  endtask

  task automatic test_random_stream();
    localparam int N = 150;
    logic [31:0] words [N];
    int idx, got;
    bit acc;
    dec_t a, e;
    for (int i = 0; i < N; i++)
      words[i] = mk(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15), $urandom);
    q.delete(); idx = 0; got = 0; in_valid = 2'b00;
    for (int c = 0; c < 3000 && got < N; c++) begin
      if (!in_valid[0] && idx < N && $urandom_range(0, 3) != 0) begin in_valid[0] = 1'b1; in32 = words[idx]; end
      out_ready = ($urandom_range(0, 3) != 0);
      smp();
      acc = 0;
      if (out_valid[0] && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_extra: output with empty queue"); end
        else begin
          e = ref_dec(q.pop_front()); a = act(0);
          if (a !== e) begin errors++; $display("FAIL rnd_data n%0d: got %h want %h", got, a, e); end
        end
        got++;
      end
      if (in_valid[0] && in_ready[0]) begin q.push_back(in32); idx++; acc = 1; end
      step();
      if (acc) in_valid[0] = 1'b0;
    end
    checks++;
    if (got != N || q.size() != 0) begin errors++; $display("FAIL rnd_count: got %0d left %0d want %0d 0", got, q.size(), N); end
    in_valid = 2'b00; out_ready = 1;
    repeat (4) step();
  endtask

  task automatic test_load_use(int g);
    int lat;
    logic [31:0] dep;
    dec_t a, e;
    lat = (g == 1) ? 3 : 1;
    out_ready = 1; in32 = mk(0, 1, 7, 4, 0); in_valid = (g == 1) ? 2'b10 : 2'b01;
    smp();
    checks++;
    if (in_ready[g] !== 1'b1) begin errors++; $display("FAIL lu_load_rdy g%0d: got %b want 1", g, in_ready[g]); end
    step();
    dep = mk(0, 7, 2, 4'b1000, $urandom); in32 = dep;
    smp(); a = act(g);
    checks++;
    if (out_valid[g] !== 1'b1 || a.we1 !== 1'b1 || stall[g] !== 1'b1) begin
      errors++; $display("FAIL lu_T g%0d: ov=%b we1=%b stall=%b want 1 1 1", g, out_valid[g], a.we1, stall[g]);
    end
    step();
    for (int k = 1; k <= lat + 1; k++) begin
      smp();
      checks++;
      if (out_valid[g] !== 1'(k == lat + 1)) begin errors++; $display("FAIL lu_ov g%0d k%0d: got %b want %b", g, k, out_valid[g], k == lat + 1); end
      if (k <= lat) begin
        checks++;
        if (stall[g] !== 1'(k < lat)) begin errors++; $display("FAIL lu_stall g%0d k%0d: got %b want %b", g, k, stall[g], k < lat); end
      end else begin
        a = act(g); e = ref_dec(dep);
        checks++;
        if (a !== e) begin errors++; $display("FAIL lu_dep g%0d: got %h want %h", g, a, e); end
      end
      step();
      if (k == lat) in_valid = 2'b00;
    end
    step();
    // Immediate-mode word whose rt bits name the load target: no dependence.
    in32 = mk(0, 1, 7, 4, 0); in_valid = (g == 1) ? 2'b10 : 2'b01;
    smp(); step();
    dep = mk(1, 3, 2, 4'b1000, (7 << 9) | 5); in32 = dep;
    smp();
    checks++;
    if (stall[g] !== 1'b0 || in_ready[g] !== 1'b1) begin
      errors++; $display("FAIL lu_imm_nostall g%0d: stall=%b rdy=%b want 0 1", g, stall[g], in_ready[g]);
    end
    step(); in_valid = 2'b00; smp();
    a = act(g); e = ref_dec(dep);
    checks++;
    if (out_valid[g] !== 1'b1 || a !== e) begin errors++; $display("FAIL lu_imm_out g%0d: ov=%b got %h want %h", g, out_valid[g], a, e); end
    repeat (5) step();
  endtask

  task automatic test_flush();
    logic [31:0] dep;
    dec_t a, e;
    out_ready = 0; in_valid = 2'b10; in32 = mk(0, 1, 7, 4, 0);
    smp(); step();
    dep = mk(0, 7, 3, 0, $urandom); in32 = dep;
    smp();
    checks++;
    if (stall[1] !== 1'b1) begin errors++; $display("FAIL fl_stall: got %b want 1", stall[1]); end
    step(); flush = 1; smp();
    checks++;
    if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL fl_rdy: got %b want 0", in_ready[1]); end
    step(); flush = 0; out_ready = 1; smp();
    checks++;
    if (out_valid[1] !== 1'b0 || stall[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL fl_after: ov=%b stall=%b rdy=%b want 0 0 1", out_valid[1], stall[1], in_ready[1]);
    end
    step(); in_valid = 2'b00; smp();
    a = act(1); e = ref_dec(dep);
    checks++;
    if (out_valid[1] !== 1'b1 || a !== e) begin errors++; $display("FAIL fl_dep: ov=%b got %h want %h", out_valid[1], a, e); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] dep;
    dec_t a, e;
    out_ready = 1; in_valid = 2'b10; in32 = mk(0, 1, 7, 4, 0);
    smp(); step();
    dep = mk(0, 7, 4, 9, $urandom); in32 = dep;
    smp(); step();
    rst = 1; smp();
    checks++;
    if (stall[1] !== 1'b0 || in_ready[1] !== 1'b0) begin
      errors++; $display("FAIL rs_during: stall=%b rdy=%b want 0 0", stall[1], in_ready[1]);
    end
    step(); rst = 0; smp();
    a = act(1);
    checks++;
    if (out_valid[1] !== 1'b0 || a !== '0 || stall[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL rs_after: ov=%b fields=%h stall=%b rdy=%b want 0 0 0 1", out_valid[1], a, stall[1], in_ready[1]);
    end
    step(); in_valid = 2'b00; smp();
    a = act(1); e = ref_dec(dep);
    checks++;
    if (out_valid[1] !== 1'b1 || a !== e) begin errors++; $display("FAIL rs_dep: ov=%b got %h want %h", out_valid[1], a, e); end
    step();
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 2'b00; out_ready = 1; in32 = '0;
    test_reset();
    test_basic();
    test_opcode_sweep();
    test_backpressure();
    test_random_stream();
    test_load_use(0);
    test_load_use(1);
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want bench to finish");
    $fatal(1);
  end

endmodule
